tcp_rx_ctrl: RTL
================

Name: tcp_rx_ctrl

Overview:
Receive-side TCP control for the network processor. Takes parsed header fields of each inbound segment, waits for the end-of-packet verdict, then classifies the segment and holds one message for the connection state machine with a valid/ack handshake. Tracks receive-sequence state: rcv_nxt, sync flag, peer ack number and peer window. Sits between the RX TCP header parser and the connection FSM, opposite the TX header controller.

Parameters:
none

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_seq_number  in  32  segment sequence number
i_ack_number  in  32  segment acknowledgement number
i_flags  in  8  TCP flags; FIN=bit0, SYN=1, RST=2, PSH=3, ACK=4
i_window_size  in  16  advertised window
i_payload_len  in  16  payload bytes in segment
i_hdr_valid  in  1  header fields valid
o_hdr_ready  out  1  header accepted when valid&ready
i_packet_done  in  1  one-cycle pulse at end of segment
i_packet_err  in  1  qualifies i_packet_done; 1 = checksum/length error, discard
i_clear  in  1  one-cycle pulse: drop sync (connection closed)
o_rx_msg  out  3  0 NONE,1 SYN,2 SYNACK,3 ACK,4 DATA,5 FIN,6 RST,7 OOO
o_rx_msg_valid  out  1  message pending
i_rx_msg_ack  in  1  consumer takes message
o_rcv_nxt  out  32  next expected sequence number
o_synced  out  1  rcv_nxt valid (SYN seen)
o_peer_ack  out  32  last accepted ack number
o_peer_window  out  16  last accepted window

Behaviour:
- Reset: state IDLE; o_hdr_ready=1; o_rx_msg=0; o_rx_msg_valid=0; o_rcv_nxt=0; o_synced=0; o_peer_ack=0; o_peer_window=0; capture regs 0.
- FSM: IDLE, WAIT_DONE, POST.
- IDLE: o_hdr_ready=1. On i_hdr_valid, capture seq, ack, flags, window, payload_len; go WAIT_DONE next cycle. i_packet_done in IDLE is ignored.
- WAIT_DONE: o_hdr_ready=0; headers ignored.
  - On i_packet_done with i_packet_err=1: no state update, no message, go IDLE.
  - On i_packet_done with i_packet_err=0: classify, commit updates in the same edge, go POST if msg!=NONE, else IDLE.
- Classification priority, on captured fields:
  - RST set: if !synced or seq==rcv_nxt -> RST, synced<=0; else NONE (dropped).
  - SYN&ACK -> SYNACK; SYN only -> SYN. Both: rcv_nxt<=seq+1 (mod 2^32), synced<=1. SYN accepted regardless of sync state.
  - Not synced and no SYN/RST -> NONE, no update.
  - Synced and seq!=rcv_nxt -> OOO, rcv_nxt unchanged (consumer sends duplicate ACK).
  - FIN -> FIN, rcv_nxt<=rcv_nxt+payload_len+1.
  - payload_len!=0 -> DATA, rcv_nxt<=rcv_nxt+payload_len.
  - ACK only -> ACK.
  - Otherwise NONE.
- ACK flag set and segment not dropped/OOO/RST: o_peer_ack<=ack, o_peer_window<=window. SYNACK updates them too.
- Sequence arithmetic is 32-bit unsigned, wraps at 2^32 (0xFFFFFFFF+1=0).
- POST: o_rx_msg_valid=1, o_rx_msg stable, o_hdr_ready=0. On i_rx_msg_ack: valid<=0, msg<=0, go IDLE. Ack in the first POST cycle is legal: one-cycle message. i_rx_msg_ack outside POST is ignored.
- Latency: message valid 1 cycle after i_packet_done. o_rcv_nxt, o_synced, o_peer_ack and o_peer_window update on that same edge.
- i_clear: synced<=0 in any state. Coincident with a commit, i_clear wins for synced; rcv_nxt still commits. A pending message is unaffected.
- Back-pressure: while not IDLE, upstream must hold headers. No buffering beyond one segment.
- Reset mid-operation: returns to IDLE, drops captured segment and pending message.

Test Plan:
- Reset -> o_hdr_ready=1, all outputs 0; i_packet_done alone in IDLE -> no message.
- SYN|ACK seq=0x1000 ack=0x5001 win=0x2000, done ok -> msg=2 one cycle later, rcv_nxt=0x1001, synced=1, peer_ack=0x5001, window=0x2000; held until ack, then IDLE.
- Synced rcv_nxt=0x1001, ACK seq=0x1001 len=100 -> msg=4, rcv_nxt=0x1065. Repeat with seq=0x1000 -> msg=7, rcv_nxt unchanged.
- Synced rcv_nxt=0xFFFFFFF0, FIN|ACK seq=0xFFFFFFF0 len=0x20 -> msg=5, rcv_nxt=0x00000011 (wrap).
- Valid segment with i_packet_err=1 -> no message, rcv_nxt/peer regs unchanged. RST with wrong seq while synced -> no message, synced stays 1.
- Not synced, plain ACK -> NONE. i_clear coincident with DATA commit -> synced=0, rcv_nxt advanced. i_rst during POST -> valid drops next cycle.

Source files
------------

// File: rtl/tcp_rx_ctrl.sv
// Receive-side TCP control: captures one parsed header, classifies it on the
// end-of-packet verdict and holds a single message for the connection FSM.
module tcp_rx_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_seq_number,
    input  logic [31:0] i_ack_number,
    input  logic [7:0]  i_flags,
    input  logic [15:0] i_window_size,
    input  logic [15:0] i_payload_len,
    input  logic        i_hdr_valid,
    output logic        o_hdr_ready,
    input  logic        i_packet_done,
    input  logic        i_packet_err,
    input  logic        i_clear,
    output logic [2:0]  o_rx_msg,
    output logic        o_rx_msg_valid,
    input  logic        i_rx_msg_ack,
    output logic [31:0] o_rcv_nxt,
    output logic        o_synced,
    output logic [31:0] o_peer_ack,
    output logic [15:0] o_peer_window
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        POST      = 2'd2
    } state_t;

    localparam logic [2:0] MSG_NONE   = 3'd0;
    localparam logic [2:0] MSG_SYN    = 3'd1;
    localparam logic [2:0] MSG_SYNACK = 3'd2;
    localparam logic [2:0] MSG_ACK    = 3'd3;
    localparam logic [2:0] MSG_DATA   = 3'd4;
    localparam logic [2:0] MSG_FIN    = 3'd5;
    localparam logic [2:0] MSG_RST    = 3'd6;
    localparam logic [2:0] MSG_OOO    = 3'd7;

    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_ACK = 4;

    state_t      state, state_nxt;

    logic [31:0] cap_seq;
    logic [31:0] cap_ack;
    logic [7:0]  cap_flags;
    logic [15:0] cap_win;
    logic [15:0] cap_len;

    logic [2:0]  msg;
    logic [31:0] rcv_nxt;
    logic        synced;
    logic [31:0] peer_ack;
    logic [15:0] peer_window;

    logic [2:0]  cls_msg;
    logic        cls_rcv_upd;
    logic [31:0] cls_rcv;
    logic        cls_sync_set;
    logic        cls_sync_clr;
    logic        cls_peer_upd;
    logic        seq_match;

    logic        capture;
    logic        commit;
    logic        msg_taken;

    // Segment classification on the captured header against current rcv state
    always_comb begin
        cls_msg      = MSG_NONE;
        cls_rcv_upd  = 1'b0;
        cls_rcv      = rcv_nxt;
        cls_sync_set = 1'b0;
        cls_sync_clr = 1'b0;
        cls_peer_upd = 1'b0;
        seq_match    = (cap_seq == rcv_nxt);

        if (cap_flags[FLAG_RST]) begin
            if (!synced || seq_match) begin
                cls_msg      = MSG_RST;
                cls_sync_clr = 1'b1;
            end
        end else if (cap_flags[FLAG_SYN]) begin
            cls_msg      = cap_flags[FLAG_ACK] ? MSG_SYNACK : MSG_SYN;
            cls_rcv_upd  = 1'b1;
            cls_rcv      = cap_seq + 32'd1;
            cls_sync_set = 1'b1;
            cls_peer_upd = cap_flags[FLAG_ACK];
        end else if (!synced) begin
            cls_msg = MSG_NONE;
        end else if (!seq_match) begin
            cls_msg = MSG_OOO;
        end else begin
            cls_peer_upd = cap_flags[FLAG_ACK];
            if (cap_flags[FLAG_FIN]) begin
                cls_msg     = MSG_FIN;
                cls_rcv_upd = 1'b1;
                cls_rcv     = rcv_nxt + {16'd0, cap_len} + 32'd1;
            end else if (cap_len != 16'd0) begin
                cls_msg     = MSG_DATA;
                cls_rcv_upd = 1'b1;
                cls_rcv     = rcv_nxt + {16'd0, cap_len};
            end else if (cap_flags[FLAG_ACK]) begin
                cls_msg = MSG_ACK;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        o_hdr_ready    = 1'b0;
        o_rx_msg_valid = 1'b0;
        capture        = 1'b0;
        commit         = 1'b0;
        msg_taken      = 1'b0;
        case (state)
            IDLE: begin
                o_hdr_ready = 1'b1;
                if (i_hdr_valid) begin
                    capture   = 1'b1;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_packet_done) begin
                    if (i_packet_err) begin
                        state_nxt = IDLE;
                    end else begin
                        commit    = 1'b1;
                        state_nxt = (cls_msg != MSG_NONE) ? POST : IDLE;
                    end
                end
            end
            POST: begin
                o_rx_msg_valid = 1'b1;
                if (i_rx_msg_ack) begin
                    msg_taken = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cap_seq   <= 32'd0;
            cap_ack   <= 32'd0;
            cap_flags <= 8'd0;
            cap_win   <= 16'd0;
            cap_len   <= 16'd0;
        end else if (capture) begin
            cap_seq   <= i_seq_number;
            cap_ack   <= i_ack_number;
            cap_flags <= i_flags;
            cap_win   <= i_window_size;
            cap_len   <= i_payload_len;
        end
    end

    // i_clear overrides any sync change made by the same commit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            msg         <= MSG_NONE;
            rcv_nxt     <= 32'd0;
            synced      <= 1'b0;
            peer_ack    <= 32'd0;
            peer_window <= 16'd0;
        end else begin
            if (commit) begin
                msg <= cls_msg;
            end else if (msg_taken) begin
                msg <= MSG_NONE;
            end
            if (commit && cls_rcv_upd) begin
                rcv_nxt <= cls_rcv;
            end
            if (i_clear) begin
                synced <= 1'b0;
            end else if (commit && cls_sync_set) begin
                synced <= 1'b1;
            end else if (commit && cls_sync_clr) begin
                synced <= 1'b0;
            end
            if (commit && cls_peer_upd) begin
                peer_ack    <= cap_ack;
                peer_window <= cap_win;
            end
        end
    end

    assign o_rx_msg      = msg;
    assign o_rcv_nxt     = rcv_nxt;
    assign o_synced      = synced;
    assign o_peer_ack    = peer_ack;
    assign o_peer_window = peer_window;

endmodule
